ahb_blockram_if: RTL
====================

// Module: ahb_blockram_if
// PURPOSE
// - AHB-Lite slave front end that drives the byte-write Block_RAM port: clka, addra, dina, wea, douta.
// - Translates address/data-phase AHB transfers into single-port RAM accesses with zero wait states.
// - Has a one-entry write buffer with read-data byte merging, resolving the port conflict between a
//   write data phase and a read address phase in the same cycle.
// - Sits between the AHB bus matrix and the on-chip code/data RAM.
// PARAMETERS
// - ADDR_WIDTH  14  RAM word-address width; RAM covers 4*2**ADDR_WIDTH bytes.
// PORTS
// - HCLK       in   1           single clock; also drives Block_RAM clka.
// - HRESET     in   1           reset, synchronous, active-high.
// - HSEL       in   1           slave select.
// - HADDR      in   32          byte address; word = HADDR[ADDR_WIDTH+1:2].
// - HTRANS     in   2           transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a valid transfer.
// - HSIZE      in   3           0=byte, 1=half, 2=word; values >2 are treated as word.
// - HWRITE     in   1           1=write.
// - HWDATA     in   32          write data, valid in the data phase.
// - HREADY     in   1           bus ready; an address phase is accepted only when HREADY=1.
// - HREADYOUT  out  1           tied to 1 (zero wait states).
// - HRESP      out  1           tied to 0 (OKAY).
// - HRDATA     out  32          read data, valid in the read data phase.
// - addra      out  ADDR_WIDTH  RAM word address.
// - dina       out  32          RAM write data.
// - wea        out  4           RAM byte write enables; all-zero means read.
// - douta      in   32          RAM read data, registered, 1-cycle latency.
// BEHAVIOUR
// - Accept condition: acc = HSEL & HTRANS[1] & HREADY. Read accept: racc = acc & ~HWRITE.
// - Byte mask from HSIZE/HADDR[1:0]:
//   - byte: 1<<A[1:0].
//   - half: A[1] ? 4'b1100 : 4'b0011.
//   - word: 4'b1111.
//   - Misaligned low bits are ignored.
// - On acc, register a data-phase descriptor: dp_wr, dp_rd, dp_addr, dp_mask. Cleared when HREADY=1
//   and no new accept.
// - RAM port arbitration per cycle, fixed priority:
//   1. racc: addra = HADDR word, wea = 0. douta appears in the next cycle, i.e. the read's data phase.
//   2. Else if dp_wr (write data phase): direct write. addra = dp_addr, dina = HWDATA, wea = dp_mask.
//   3. Else if buf_valid: drain. addra = buf_addr, dina = buf_data, wea = buf_mask; buf_valid clears.
//   4. Else: wea = 0, addra = HADDR word (don't care).
// - Write buffer load: when dp_wr and racc coincide, buffer captures {dp_addr, dp_mask, HWDATA} at the
//   clock edge and sets buf_valid.
// - Invariant: a buffer load and a direct write never find buf_valid=1.
//   - Reason: the cycle of a write's address phase is never a read address phase, so the buffer
//     drains there.
//   - Verification asserts this invariant; the design need not handle a violation.
// - Read merge in the read data phase: if buf_valid and buf_addr == dp_addr, then for each byte i,
//   HRDATA byte i = buf_mask[i] ? buf_data byte i : douta byte i. Otherwise HRDATA = douta.
//   Forwarding gives read-after-write coherence with zero wait states.
// - Full 32-bit word is returned for all HSIZE; the master selects lanes.
// - IDLE/BUSY transfers and HSEL=0: no descriptor is captured, but a pending buffer still drains in
//   free cycles.
// - Reset (HRESET=1 at an edge), including mid-transfer:
//   - buf_valid = 0 and the pending buffered write is discarded.
//   - dp_wr = dp_rd = 0, dp_addr = 0, dp_mask = 0.
//   - wea is forced to 0 while HRESET=1.
//   - HREADYOUT = 1, HRESP = 0; HRDATA follows douta.
// - Address bits above ADDR_WIDTH+1 are ignored (aliasing); no error response.
// TESTING
// - Word write 0x0000_0010 = 0xDEADBEEF, idle, read 0x10 -> HRDATA = 0xDEADBEEF in data phase,
//   HREADYOUT = 1 throughout.
// - Byte writes 0xAA at 0x21 and 0x55 at 0x23 -> wea = 4'b0010 then 4'b1000; word read 0x20 ->
//   0x55xxAAxx with other bytes unchanged.
// - Write 0x30 = 0x12345678 immediately followed by read 0x30 -> buffer loads; HRDATA = 0x12345678
//   via merge; write reaches RAM on the first free cycle.
// - Half write 0x42 = 0xBEEF followed by reads 0x40, 0x44, 0x40 back-to-back -> buffer holds through
//   the reads; both 0x40 reads return 0xBEEFxxxx; a later idle drains with wea = 4'b1100.
// - Continuous W,R,W,R stream over 64 random addresses vs. reference model -> all reads match;
//   buffer-overrun assertion never fires.
// - Assert HRESET with buf_valid = 1 -> buffered write is lost (location keeps old value), wea = 0
//   during reset, normal operation resumes on the next cycle.

Source files
------------

// File: rtl/ahb_blockram_if_if.sv
// AHB-Lite bus bundle for the block-RAM slave front end.
interface ahb_blockram_if_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_blockram_if.sv
// AHB-Lite slave front end for a single-port byte-write block RAM.
// Zero wait states; a one-entry write buffer absorbs a write data phase that
// collides with a read address phase, and read data is merged with it.
module ahb_blockram_if #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_blockram_if_if.slave      ahb,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  input  logic [31:0]           douta
);

  typedef enum logic [1:0] {
    PORT_READ,
    PORT_DIRECT,
    PORT_DRAIN,
    PORT_IDLE
  } port_sel_t;

  port_sel_t             port_sel;
  logic                  acc;
  logic                  racc;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic [3:0]            amask;

  logic                  dp_wr;
  logic                  dp_rd;
  logic [ADDR_WIDTH-1:0] dp_addr;
  logic [3:0]            dp_mask;

  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [3:0]            buf_mask;
  logic [31:0]           buf_data;

  logic                  buf_hit;
  logic [31:0]           rdata;

  logic                  unused_bits;

  assign acc        = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign racc       = acc & ~ahb.HWRITE;
  assign haddr_word = ahb.HADDR[ADDR_WIDTH+1:2];
  assign unused_bits = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign ahb.HRDATA    = rdata;

  // Byte-lane mask of the address phase; misaligned low bits are ignored.
  always_comb begin
    amask = 4'b1111;
    case (ahb.HSIZE)
      3'd0:    amask = 4'b0001 << ahb.HADDR[1:0];
      3'd1:    amask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
      default: amask = 4'b1111;
    endcase
  end

  // Data-phase descriptor: captured on accept, cleared on an empty ready cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_wr   <= 1'b0;
      dp_rd   <= 1'b0;
      dp_addr <= '0;
      dp_mask <= '0;
    end else if (acc) begin
      dp_wr   <= ahb.HWRITE;
      dp_rd   <= ~ahb.HWRITE;
      dp_addr <= haddr_word;
      dp_mask <= amask;
    end else if (ahb.HREADY) begin
      dp_wr   <= 1'b0;
      dp_rd   <= 1'b0;
      dp_addr <= '0;
      dp_mask <= '0;
    end
  end

  // RAM port arbitration: read address > direct write > buffer drain.
  always_comb begin
    port_sel = PORT_IDLE;
    addra    = haddr_word;
    dina     = ahb.HWDATA;
    wea      = '0;
    if (racc) begin
      port_sel = PORT_READ;
    end else if (dp_wr) begin
      port_sel = PORT_DIRECT;
      addra    = dp_addr;
      wea      = dp_mask;
    end else if (buf_valid) begin
      port_sel = PORT_DRAIN;
      addra    = buf_addr;
      dina     = buf_data;
      wea      = buf_mask;
    end
    if (HRESET) begin
      wea = '0;
    end
  end

  // Write buffer: loads when a write data phase loses the port to a read,
  // empties on the first cycle the port is free.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_mask  <= '0;
      buf_data  <= '0;
    end else if (dp_wr && racc) begin
      buf_valid <= 1'b1;
      buf_addr  <= dp_addr;
      buf_mask  <= dp_mask;
      buf_data  <= ahb.HWDATA;
    end else if (port_sel == PORT_DRAIN) begin
      buf_valid <= 1'b0;
    end
  end

  // Read data: forward buffered bytes over stale RAM bytes on an address hit.
  always_comb begin
    buf_hit = buf_valid & dp_rd & (buf_addr == dp_addr);
    rdata   = douta;
    for (int unsigned i = 0; i < 4; i++) begin
      if (buf_hit && buf_mask[i]) begin
        rdata[8*i +: 8] = buf_data[8*i +: 8];
      end
    end
  end

endmodule
